// File: rtl/sampler_pkg.sv
// ---------------------------------------------------------------------------
// sampler_pkg
// Shared definitions for the periodic sample-capture slot core:
//   - slot register addresses
//   - status / control bit positions
//   - ctrl_t, the layout of the control word written through REG_STAT
// ---------------------------------------------------------------------------
package sampler_pkg;

  // Slot register map. The control word (enable / clear) is written through
  // REG_STAT; REG_CTRL only reads the enable bit back.
  localparam logic [4:0] REG_DATA   = 5'd0;  // rd: FIFO head, wr: pop
  localparam logic [4:0] REG_STAT   = 5'd1;  // rd: status, wr: control
  localparam logic [4:0] REG_PERIOD = 5'd2;  // rd/wr: sample period P
  localparam logic [4:0] REG_CTRL   = 5'd3;  // rd: enable readback

  // Status word bit positions (count occupies the low bits).
  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;

  // Enable readback bit position.
  localparam int CTRL_ENABLE = 0;

  // Timestamp field width (addr 0 bits [31:16]).
  localparam int TSTAMP_W = 16;

  // Control word layout: bit 1 = clear (self-clearing), bit 0 = enable.
  typedef struct packed {
    logic clear;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/sampler_fifo.sv
// ---------------------------------------------------------------------------
// sampler_fifo
// Register-file FIFO with synchronous write and combinational head read.
// Depth is 2^ADDR_W words; pointers wrap naturally modulo the depth.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   clr    in   synchronous flush, dominates push/pop
//   push   in   write din (ignored when full unless popping the same cycle)
//   pop    in   advance head (ignored when empty)
//   din    in   [DW-1:0] write data
//   dout   out  [DW-1:0] head word (undefined when empty)
//   count  out  [ADDR_W:0] occupancy
//   empty  out  count == 0
//   full   out  count == 2^ADDR_W
// ---------------------------------------------------------------------------
module sampler_fifo #(
  parameter int DW     = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DW-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              do_push;
  logic              do_pop;

  assign empty = (cnt == '0);
  // Occupancy never exceeds DEPTH, so the MSB alone marks "full".
  assign full  = cnt[ADDR_W];

  // A pop frees the slot being written, so push+pop is legal when full.
  // When empty the pop has nothing to remove and only the push happens.
  assign do_pop  = pop  & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked entirely by
  // the pointers and count, which keeps this mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/chu_sampler_core.sv
// ---------------------------------------------------------------------------
// chu_sampler_core
// FPro MMIO slot that captures din every P+1 cycles into a FIFO which
// software drains through the slot registers.
//
// Build option: define SAMPLER_TSTAMP_EN to add a free-running 16-bit cycle
// counter whose value at each capture edge is stored with the sample and
// returned in addr 0 [31:16]. Without it, those bits read 0.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   cs       in   slot chip select
//   read     in   slot read strobe (reads have no side effects)
//   write    in   slot write strobe
//   addr     in   [4:0] register address
//   rd_data  out  [31:0] register read data, combinational from addr
//   wr_data  in   [31:0] register write data
//   din      in   [W-1:0] data to sample
// ---------------------------------------------------------------------------
module chu_sampler_core #(
  parameter int W      = 16,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  output logic [31:0]   rd_data,
  input  logic [31:0]   wr_data,
  input  logic [W-1:0]  din
);

  import sampler_pkg::*;

`ifdef SAMPLER_TSTAMP_EN
  localparam int DW = W + TSTAMP_W;
`else
  localparam int DW = W;
`endif

  logic                wr_en;
  logic                wr_pop;
  logic                wr_ctrl;
  logic                wr_period;
  ctrl_t               ctrl_wr;
  logic                clear;

  logic                enable;
  logic [31:0]         period;
  logic [31:0]         tick_cnt;
  logic                overflow;
  logic                sample_hit;

  logic [DW-1:0]       fifo_din;
  logic [DW-1:0]       fifo_dout;
  logic [ADDR_W:0]     count;
  logic                empty;
  logic                full;
  logic [W-1:0]        head_data;
  logic [TSTAMP_W-1:0] head_ts;

  // The read strobe carries no side effects in this slot.
  logic                unused_read;
  assign unused_read = read;

  // ---- register write decode ----------------------------------------------
  assign wr_en     = cs & write;
  assign wr_pop    = wr_en && (addr == REG_DATA);
  assign wr_ctrl   = wr_en && (addr == REG_STAT);
  assign wr_period = wr_en && (addr == REG_PERIOD);
  assign ctrl_wr   = ctrl_t'(wr_data[1:0]);
  assign clear     = wr_ctrl && ctrl_wr.clear;

  // ---- period counter -----------------------------------------------------
  assign sample_hit = enable && (tick_cnt == period);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      period   <= '0;
      tick_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl)   enable <= ctrl_wr.enable;
      if (wr_period) period <= wr_data;

      // Counter parks at 0 while disabled so a fresh enable always starts a
      // full P+1 interval.
      if (clear || !enable || sample_hit) tick_cnt <= '0;
      else                                tick_cnt <= tick_cnt + 32'd1;

      // A sample is only lost when full and nothing leaves the same cycle.
      if (clear)                                 overflow <= 1'b0;
      else if (sample_hit && full && !wr_pop)    overflow <= 1'b1;
    end
  end

  // ---- optional timestamp -------------------------------------------------
`ifdef SAMPLER_TSTAMP_EN
  logic [TSTAMP_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TSTAMP_W'(1);
  end

  assign fifo_din = {ts_cnt, din};
  assign head_ts  = fifo_dout[DW-1:W];
`else
  assign fifo_din = din;
  assign head_ts  = '0;
`endif

  assign head_data = fifo_dout[W-1:0];

  // ---- sample FIFO --------------------------------------------------------
  sampler_fifo #(
    .DW     (DW),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .push  (sample_hit),
    .pop   (wr_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // ---- register read mux --------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_DATA: begin
        rd_data[W-1:0]  = head_data;
        rd_data[31:16]  = head_ts;
      end
      REG_STAT: begin
        rd_data[ADDR_W:0]   = count;
        rd_data[STAT_EMPTY] = empty;
        rd_data[STAT_FULL]  = full;
        rd_data[STAT_OVF]   = overflow;
      end
      REG_PERIOD: rd_data = period;
      REG_CTRL:   rd_data[CTRL_ENABLE] = enable;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_chu_sampler_core.sv
// ---------------------------------------------------------------------------
// tb_chu_sampler_core
// Scoreboarded bench for chu_sampler_core with a 4-deep FIFO (ADDR_W=2).
// Register reads push their hand-computed expectation into a queue; a
// monitor on the falling edge pops and compares whenever a read strobe is
// presented. Timestamp checks are built only with SAMPLER_TSTAMP_EN.
// ---------------------------------------------------------------------------
module tb_chu_sampler_core;

  import sampler_pkg::*;

  localparam int W      = 16;
  localparam int ADDR_W = 2;

`ifdef SAMPLER_TSTAMP_EN
  localparam logic [31:0] HEAD_MASK = 32'h0000_FFFF;
`else
  localparam logic [31:0] HEAD_MASK = 32'hFFFF_FFFF;
`endif

  logic          clk;
  logic          reset;
  logic          cs;
  logic          read;
  logic          write;
  logic [4:0]    addr;
  logic [31:0]   rd_data;
  logic [31:0]   wr_data;
  logic [W-1:0]  din;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t exp_q[$];

  chu_sampler_core #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .rd_data (rd_data),
    .wr_data (wr_data),
    .din     (din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: whenever a read strobe is on the bus, compare against the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cs && read) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_read", rd_data, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check(e.name, rd_data & e.mask, e.exp & e.mask);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e,
                    input logic [31:0] m, input string n);
    exp_t x;
    x.name = n; x.exp = e; x.mask = m;
    exp_q.push_back(x);
    cs = 1'b1; read = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef SAMPLER_TSTAMP_EN
  // Cycles since reset release, used only to steer the timestamp test
  // across the 16-bit wrap.
  int unsigned cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Untracked look at rd_data (no read strobe, so the monitor ignores it).
  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask
`endif

  initial begin
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; din = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // ---- reset state ----
    rd(REG_STAT,   32'h0001_0000, '1, "rst_status");
    rd(REG_PERIOD, 32'h0,         '1, "rst_period");
    rd(REG_CTRL,   32'h0,         '1, "rst_enable");
    rd(5'd9,       32'h0,         '1, "unmapped_addr");

    // ---- P=3, constant din: samples every 4 cycles ----
    din = 16'h0ABC;
    wr(REG_PERIOD, 32'd3);
    wr(REG_STAT, 32'h1);               // enable; samples at +4,+8,+12
    idle(12);
    rd(REG_STAT, 32'h0000_0003, '1,        "p3_count");
    rd(REG_DATA, 32'h0000_0ABC, HEAD_MASK, "p3_head");
    wr(REG_STAT, 32'h0);               // disable before the 4th sample
    wr(REG_STAT, 32'h2);               // clear
    rd(REG_STAT, 32'h0001_0000, '1, "p3_cleared");

    // ---- P=0, six samples into a 4-deep FIFO ----
    wr(REG_PERIOD, 32'd0);
    wr(REG_STAT, 32'h1);
    for (int k = 0; k < 5; k++) begin
      din = 16'h1001 + 16'(k);
      @(posedge clk); #1;
    end
    din = 16'h1006;
    wr(REG_STAT, 32'h0);               // 6th sample still taken on this edge
    rd(REG_STAT, 32'h0006_0004, '1,        "full_ovf_status");
    rd(REG_DATA, 32'h0000_1001, HEAD_MASK, "full_head_first");

    // ---- push and pop on the same edge while full ----
    din = 16'h2222;
    wr(REG_STAT, 32'h1);
    wr(REG_DATA, 32'h0);               // pop 0x1001, push 0x2222
    wr(REG_STAT, 32'h0);               // one more push here is dropped
    rd(REG_STAT, 32'h0006_0004, '1,        "pushpop_full_status");
    rd(REG_DATA, 32'h0000_1002, HEAD_MASK, "pushpop_full_head");
    wr(REG_DATA, 32'h0);
    rd(REG_DATA, 32'h0000_1003, HEAD_MASK, "order_third");
    rd(REG_STAT, 32'h0004_0003, '1,        "pre_clear_status");

    // ---- clear while enabled, count=3, overflow=1 ----
    wr(REG_PERIOD, 32'd4);
    rd(REG_PERIOD, 32'd4, '1, "period_readback");
    din = 16'h3333;
    wr(REG_STAT, 32'h1);               // enable
    wr(REG_STAT, 32'h3);               // clear + keep enable; tick restarts
    rd(REG_STAT, 32'h0001_0000, '1, "clear_status");
    rd(REG_CTRL, 32'h0000_0001, '1, "clear_keeps_enable");
    idle(2);
    rd(REG_STAT, 32'h0001_0000, '1, "clear_tick_zeroed");  // 4 edges after clear
    rd(REG_STAT, 32'h0000_0001, '1, "post_clear_first");   // 5th edge sampled
    rd(REG_DATA, 32'h0000_3333, HEAD_MASK, "post_clear_head");
    idle(3);
    rd(REG_STAT, 32'h0000_0002, '1, "pre_reset_count");

    // ---- asynchronous reset mid-run ----
    reset = 1'b0;
    begin
      exp_t x;
      x.name = "stat_in_reset"; x.exp = 32'h0001_0000; x.mask = '1;
      exp_q.push_back(x);
    end
    cs = 1'b1; read = 1'b1; addr = REG_STAT;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rd(REG_CTRL,   32'h0,         '1, "post_reset_enable");
    rd(REG_PERIOD, 32'h0,         '1, "post_reset_period");
    idle(8);
    rd(REG_STAT,   32'h0001_0000, '1, "post_reset_idle");

    // ---- sampling resumes after enable rewritten (P=0) ----
    din = 16'h4444;
    wr(REG_STAT, 32'h1);
    wr(REG_STAT, 32'h0);               // single sample on this edge
    rd(REG_STAT, 32'h0000_0001, '1,        "restart_count");
    rd(REG_DATA, 32'h0000_4444, HEAD_MASK, "restart_head");

    // ---- push and pop together when empty ----
    wr(REG_DATA, 32'h0);               // drain to empty
    wr(REG_DATA, 32'h0);               // pop on empty: ignored
    rd(REG_STAT, 32'h0001_0000, '1, "pop_empty_ignored");
    wr(REG_STAT, 32'h1);
    wr(REG_DATA, 32'h0);               // push occurs, pop ignored
    wr(REG_STAT, 32'h0);               // one more push
    rd(REG_STAT, 32'h0000_0002, '1,        "pushpop_empty_count");
    rd(REG_DATA, 32'h0000_4444, HEAD_MASK, "pushpop_empty_head");

`ifdef SAMPLER_TSTAMP_EN
    // ---- timestamps P=9, straddling the 0xFFFF -> 0 wrap ----
    begin
      logic [31:0] v;
      logic [15:0] prev_ts;
      logic [15:0] dts;
      logic        got;
      prev_ts = '0;
      while (cyc < 32'd65520) begin
        @(posedge clk); #1;
      end
      din = 16'h5A5A;
      wr(REG_PERIOD, 32'd9);
      wr(REG_STAT, 32'h3);             // flush + enable
      for (int i = 0; i < 5; i++) begin
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
          peek(REG_STAT, v);
          if (v[ADDR_W:0] != '0) got = 1'b1;
          else begin
            @(posedge clk); #1;
          end
        end
        check("ts_sample_arrived", {31'b0, got}, 32'h1);
        peek(REG_DATA, v);
        check("ts_data", {16'h0, v[15:0]}, 32'h0000_5A5A);
        if (i > 0) begin
          dts = v[31:16] - prev_ts;
          check("ts_delta", {16'h0, dts}, 32'd10);
        end
        prev_ts = v[31:16];
        wr(REG_DATA, 32'h0);
      end
    end
`endif

    idle(2);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
